// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the default datapath width.
package mdu_pkg;

    localparam int unsigned MDU_XLEN = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } mdu_state_e;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative restoring radix-2 divider on operand magnitudes, one quotient bit
// per cycle; sign fixup and divide-by-zero results are applied on the outputs.
module div_radix2
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            cancel,
    output logic            busy,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    logic [CW-1:0]   count;
    logic [XLEN-1:0] quo, rem, dvs;
    logic            neg_q, neg_r, div_zero;
    logic [XLEN-1:0] dividend_mag, divisor_mag;
    logic [XLEN:0]   shifted, diff;

    always_comb begin
        dividend_mag = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
        divisor_mag  = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
        shifted      = {rem, quo[XLEN-1]};
        diff         = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (cancel) begin
            count <= '0;
        end else if (start) begin
            quo      <= dividend_mag;
            rem      <= '0;
            dvs      <= divisor_mag;
            neg_q    <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r    <= is_signed & dividend[XLEN-1];
            div_zero <= (divisor == '0);
            count    <= CW'(XLEN);
        end else if (count != '0) begin
            count <= count - CW'(1);
            // A zero divisor never subtracts, so rem ends up holding |dividend|.
            if (!diff[XLEN] && !div_zero) begin
                rem <= diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= shifted[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end
    end

    // done flags the cycle whose closing edge performs the final iteration.
    assign busy      = (count != '0);
    assign done      = (count == CW'(1));
    assign quotient  = div_zero ? '1 : (neg_q ? -quo : quo);
    assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with private HI/LO: MUL_LAT-cycle multiplier, iterative
// divider, MTHI/MTLO, flush-cancel and a single outstanding op.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN    = MDU_XLEN,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic            cancel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    mdu_state_e        state;
    logic [2:0]        cnt;
    logic              busy_q, done_q, sel_div;
    logic [2*XLEN-1:0] mul_a, mul_b, product;
    logic              accept, signed_op, div_start;
    logic              div_busy, div_done;
    logic [XLEN-1:0]   div_q, div_r;

    assign req_ready = ~reset & (state == ST_IDLE) & ~cancel;
    assign accept    = req_valid & req_ready;
    assign signed_op = is_signed_op(req_op);
    assign div_start = accept & ((req_op == MDU_DIV) || (req_op == MDU_DIVU));
    assign product   = mul_a * mul_b;
    assign busy      = busy_q;
    // A cancel landing in the result cycle suppresses both the write and the pulse.
    assign done      = done_q & ~(cancel & (state == ST_FIN));

    div_radix2 #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .is_signed (signed_op),
        .dividend  (req_src1),
        .divisor   (req_src2),
        .cancel    (cancel),
        .busy      (div_busy),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_div <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    case (req_op)
                        MDU_MULT, MDU_MULTU: begin
                            mul_a   <= {{XLEN{signed_op & req_src1[XLEN-1]}}, req_src1};
                            mul_b   <= {{XLEN{signed_op & req_src2[XLEN-1]}}, req_src2};
                            sel_div <= 1'b0;
                            busy_q  <= 1'b1;
                            if (MUL_LAT <= 1) begin
                                state  <= ST_FIN;
                                done_q <= 1'b1;
                            end else begin
                                state <= ST_MUL;
                                cnt   <= 3'(MUL_LAT) - 3'd2;
                            end
                        end
                        MDU_DIV, MDU_DIVU: begin
                            sel_div <= 1'b1;
                            busy_q  <= 1'b1;
                            state   <= ST_DIV;
                        end
                        MDU_MTHI: begin
                            hi_o   <= req_src1;
                            done_q <= 1'b1;
                        end
                        MDU_MTLO: begin
                            lo_o   <= req_src1;
                            done_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MUL: begin
                    if (cancel) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (cnt == '0) begin
                        state  <= ST_FIN;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_DIV: begin
                    // Losing the divider without a done is treated like a flush.
                    if (cancel || !div_busy) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else if (div_done) begin
                        state  <= ST_FIN;
                        done_q <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    if (!cancel) begin
                        if (sel_div) {hi_o, lo_o} <= {div_r, div_q};
                        else         {hi_o, lo_o} <= product;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32, MUL_LAT=2) with hand-computed
// results, latency and busy-length expectations.
module tb_muldiv_unit;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = XLEN + 1;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;
    logic            cancel;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure latency to done and busy cycles, then check HI/LO.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input int exp_lat, input int exp_busy,
                         input logic [XLEN-1:0] exp_hi, input logic [XLEN-1:0] exp_lo);
        int n, nbusy;
        logic [XLEN-1:0] old_hi;
        old_hi    = hi_o;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        req_src1  = ~a;
        req_src2  = ~b;
        n = 1;
        nbusy = 0;
        while (!done && n < 100) begin
            nbusy += int'(busy);
            step();
            n++;
        end
        nbusy += int'(busy);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy"}, 64'(nbusy), 64'(exp_busy));
        if (exp_busy != 0) check({tag, "_hi_old"}, 64'(hi_o), 64'(old_hi));
        step();
        check({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
        check({tag, "_idle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int ndone;
        logic [XLEN-1:0] old_lo, old_hi;
        clk = 1'b0; reset = 1'b1; req_valid = 1'b0; req_op = '0;
        req_src1 = '0; req_src2 = '0; cancel = 1'b0;

        step();
        check("rst_ready", 64'(req_ready), 64'd0);
        step();
        check("rst_ready2", 64'(req_ready), 64'd0);
        check("rst_state", 64'({busy, done, hi_o, lo_o}), 64'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 64'(req_ready), 64'd1);

        do_op("mult_neg",  3'd0, 32'hFFFF_FFFD, 32'd7, MUL_LAT, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("multu",     3'd1, 32'hFFFF_FFFF, 32'd2, MUL_LAT, MUL_LAT, 32'h0000_0001, 32'hFFFF_FFFE);
        do_op("mthi",      3'd4, 32'hAAAA_5555, 32'd0, 1, 0, 32'hAAAA_5555, 32'hFFFF_FFFE);
        do_op("mtlo",      3'd5, 32'h0BAD_F00D, 32'd0, 1, 0, 32'hAAAA_5555, 32'h0BAD_F00D);
        do_op("divu",      3'd3, 32'd100, 32'd7, DIV_LAT, DIV_LAT, 32'd2, 32'd14);
        do_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2, DIV_LAT, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, DIV_LAT, 32'd0, 32'h8000_0000);
        do_op("divu_zero", 3'd3, 32'd5, 32'd0, DIV_LAT, DIV_LAT, 32'd5, 32'hFFFF_FFFF);
        do_op("div_zero",  3'd2, 32'hFFFF_FFFB, 32'd0, DIV_LAT, DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        do_op("div_dneg",  3'd2, 32'd7, 32'hFFFF_FFFE, DIV_LAT, DIV_LAT, 32'd1, 32'hFFFF_FFFD);
        do_op("mult_ext",  3'd0, 32'h7FFF_FFFF, 32'h8000_0000, MUL_LAT, MUL_LAT, 32'hC000_0000, 32'h8000_0000);

        // DIV cancelled at accept+10, then MTHI.
        old_lo = lo_o;
        req_valid = 1'b1; req_op = 3'd2; req_src1 = 32'd100; req_src2 = 32'd3;
        step();
        req_valid = 1'b0;
        ndone = 0;
        repeat (9) begin ndone += int'(done); step(); end
        cancel = 1'b1;
        ndone += int'(done);
        step();
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        repeat (40) begin ndone += int'(done); step(); end
        check("cancel_no_done", 64'(ndone), 64'd0);
        check("cancel_lo_keep", 64'(lo_o), 64'(old_lo));
        do_op("mthi_after_cancel", 3'd4, 32'h0000_1234, 32'd0, 1, 0, 32'h0000_1234, old_lo);

        // MTLO presented together with cancel is not accepted.
        old_lo = lo_o;
        cancel = 1'b1; req_valid = 1'b1; req_op = 3'd5; req_src1 = 32'hDEAD_BEEF;
        #1;
        check("mtlo_cancel_ready", 64'(req_ready), 64'd0);
        step();
        cancel = 1'b0; req_valid = 1'b0;
        ndone = int'(done);
        step();
        ndone += int'(done);
        check("mtlo_cancel_done", 64'(ndone), 64'd0);
        check("mtlo_cancel_lo", 64'(lo_o), 64'(old_lo));

        // No-op encoding: accepted, nothing happens.
        old_hi = hi_o;
        req_valid = 1'b1; req_op = 3'd6; req_src1 = 32'h5555_AAAA;
        step();
        req_valid = 1'b0;
        ndone = 0;
        repeat (3) begin ndone += int'(done) + int'(busy); step(); end
        check("nop_quiet", 64'(ndone), 64'd0);
        check("nop_hilo", 64'({hi_o, lo_o}), {32'(old_hi), 32'(old_lo)});

        // Reset at accept+5 of a DIV.
        req_valid = 1'b1; req_op = 3'd3; req_src1 = 32'd100; req_src2 = 32'd7;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_state", 64'({busy, done, hi_o, lo_o}), 64'd0);
        ndone = 0;
        repeat (40) begin ndone += int'(done); step(); end
        check("midrst_no_done", 64'(ndone), 64'd0);
        check("midrst_hilo", 64'({hi_o, lo_o}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
